// File: rtl/ifetch_buffer.sv
// ifetch_buffer: single-outstanding instruction fetch feeding a 2-entry decode FIFO.
// Build option: define IFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.

package ifetch_buffer_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

module ifetch_buffer
    import ifetch_buffer_pkg::*;
(
    input  logic            pc_clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       head;
    fetch_entry_t       tail;
    fetch_entry_t       new_entry;
    logic               ack_ok;
    logic               bypass;
    logic               fifo_valid;
    logic               push;
    logic               pop;

    assign pc_plus4   = pc_addr + XLEN'(4);
    assign new_entry  = '{pc: imem_addr, inst: imem_rdata};

    // A response counts only when it answers a live (non-dropped) request and no redirect is in progress.
    assign ack_ok     = (state == S_REQ) && imem_ack && !flush && !rst;
    assign pc_advance = ack_ok;
    assign fifo_valid = (count != '0);

`ifdef IFETCH_BYPASS_EN
    assign bypass     = ack_ok && !fifo_valid && id_ready;
`else
    assign bypass     = 1'b0;
`endif

    assign push       = ack_ok && !bypass;
    assign pop        = fifo_valid && id_ready;
    assign id_valid   = fifo_valid || bypass;
    assign id_inst    = bypass ? imem_rdata : head.inst;
    assign id_pc      = bypass ? imem_addr  : head.pc;

    // Request FSM; a request, once raised, stays up until the memory acknowledges it.
    always_ff @(posedge pc_clk) begin
        if (rst) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!flush && (count < CNT_W'(DEPTH))) begin
                        state     <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_addr;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end else if (flush) begin
                        state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Shift-style FIFO: head always drives decode, so an empty FIFO keeps showing the last entry.
    always_ff @(posedge pc_clk) begin
        if (rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (bypass) begin
                head <= new_entry;
            end
            unique case ({push, pop})
                2'b10: begin
                    if (count == '0) begin
                        head <= new_entry;
                    end else begin
                        tail <= new_entry;
                    end
                end
                2'b01: begin
                    if (count == CNT_W'(DEPTH)) begin
                        head <= tail;
                    end
                end
                2'b11: begin
                    if (count == CNT_W'(1)) begin
                        head <= new_entry;
                    end else begin
                        head <= tail;
                        tail <= new_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed scenarios plus a randomized run checked against a queue-based fetch model.
module tb_ifetch_buffer;

    localparam logic [31:0] MASK = 32'hFFFF_0000;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        pc_clk;
    logic        rst;
    logic [31:0] pc_addr;
    logic [31:0] pc_plus4;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    ifetch_buffer dut (
        .pc_clk    (pc_clk),
        .rst       (rst),
        .pc_addr   (pc_addr),
        .pc_plus4  (pc_plus4),
        .pc_advance(pc_advance),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .id_valid  (id_valid),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .id_ready  (id_ready)
    );

    initial begin
        pc_clk = 1'b0;
        forever #5 pc_clk = ~pc_clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_cnt  = 0;
    int          mem_lat  = 0;
    int          lat_min  = 0;
    int          lat_max  = 0;
    logic [31:0] pc_reg   = 32'h0;
    logic [31:0] redirect_pc = 32'h0;

    // Reference model: one outstanding fetch plus a queue of buffered instructions.
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    ent_t        q[$];
    ent_t        m_last;
    bit          exp_adv;
    bit          exp_byp;
    bit          exp_valid;
    ent_t        exp_head;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'h2008_0005 : (a ^ MASK);
    endfunction

    task automatic model_eval();
        exp_adv   = !rst && m_busy && !m_drop && (imem_ack === 1'b1) && !flush;
        exp_byp   = BYP && exp_adv && (q.size() == 0) && id_ready;
        exp_valid = (q.size() != 0) || exp_byp;
        if (exp_byp)
            exp_head = '{pc: m_addr, inst: mem_data(m_addr)};
        else if (q.size() != 0)
            exp_head = q[0];
        else
            exp_head = m_last;
    endtask

    task automatic model_update();
        int sz;
        if (rst) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_addr = 32'h0;
            q.delete();
            m_last = '0;
            return;
        end
        sz = q.size();
        if (exp_valid) m_last = exp_head;
        if (flush) begin
            q.delete();
        end else begin
            if (sz != 0 && id_ready) void'(q.pop_front());
            if (exp_adv && !exp_byp) q.push_back('{pc: m_addr, inst: mem_data(m_addr)});
        end
        if (!m_busy) begin
            if (!flush && sz < 2) begin
                m_busy = 1'b1;
                m_addr = pc_reg;
            end
        end else if (imem_ack === 1'b1) begin
            m_busy = 1'b0;
            m_drop = 1'b0;
        end else if (flush) begin
            m_drop = 1'b1;
        end
        if (flush) pc_reg = redirect_pc;
        else if (exp_adv) pc_reg = pc_reg + 32'd4;
    endtask

    // Memory: acknowledges a held request after mem_lat extra cycles.
    task automatic drive_mem();
        if (imem_req === 1'b1) begin
            if (mem_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            mem_cnt    = 0;
            mem_lat    = $urandom_range(lat_max, lat_min);
        end
    endtask

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic advance();
        model_eval();
        model_update();
        @(posedge pc_clk);
        #1;
        pc_addr = pc_reg;
        drive_mem();
    endtask

    task automatic do_reset(input logic [31:0] pc, input int lmin, input int lmax);
        lat_min = lmin; lat_max = lmax; mem_lat = lmin; mem_cnt = 0;
        pc_reg = pc; pc_addr = pc; redirect_pc = pc;
        flush = 1'b0; id_ready = 1'b0; rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        lat_min = 0; lat_max = 0;
        pc_reg = 32'h0; pc_addr = 32'h0; redirect_pc = 32'h0;
        flush = 1'b0; id_ready = 1'b0; rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        advance();
        for (int c = 0; c < 2; c++) begin
            settle();
            n_checks++;
            if ({imem_req, pc_advance, id_valid} !== 3'b000 || imem_addr !== 32'h0 ||
                id_inst !== 32'h0 || id_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs c%0d: req=%b adv=%b valid=%b addr=%h inst=%h pc=%h, required all zero",
                         c, imem_req, pc_advance, id_valid, imem_addr, id_inst, id_pc);
            end
            if (c == 0) begin
                advance();
                rst = 1'b0;
            end
        end
        n_checks++;
        if (pc_plus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_pc_plus4: got %h, required 00000004", pc_plus4);
        end
        advance();
        settle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h, required req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] seen_pc[$];
        logic [31:0] seen_inst[$];
        int          adv_cyc[$];
        do_reset(32'h0, 0, 0);
        id_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (id_valid === 1'b1) begin
                seen_pc.push_back(id_pc);
                seen_inst.push_back(id_inst);
            end
            if (pc_advance === 1'b1) adv_cyc.push_back(c);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (seen_pc.size() <= i || seen_pc[i] !== 32'(i * 4) || seen_inst[i] !== mem_data(32'(i * 4))) begin
                n_fail++;
                $display("FAIL stream_order[%0d]: got %0d entries (pc=%h inst=%h), required pc=%h inst=%h", i,
                         seen_pc.size(), (seen_pc.size() > i) ? seen_pc[i] : 32'hx,
                         (seen_inst.size() > i) ? seen_inst[i] : 32'hx, 32'(i * 4), mem_data(32'(i * 4)));
            end
        end
        n_checks++;
        if (adv_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL stream_adv_count: got %0d pulses in 12 cycles, required 6", adv_cyc.size());
        end
        for (int i = 1; i < adv_cyc.size(); i++) begin
            n_checks++;
            if (adv_cyc[i] - adv_cyc[i-1] != 2) begin
                n_fail++;
                $display("FAIL stream_adv_spacing: pulses at %0d and %0d, required 2 apart", adv_cyc[i-1], adv_cyc[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          advs = 0;
        bit          found = 1'b0;
        do_reset(32'h0, 0, 0);
        for (int c = 0; c < 12; c++) begin
            settle();
            if (pc_advance === 1'b1) advs++;
            advance();
        end
        settle();
        n_checks++;
        if (advs != 2 || id_valid !== 1'b1 || id_pc !== 32'h0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: adv=%0d valid=%b pc=%h req=%b, required adv=2 valid=1 pc=00000000 req=0",
                     advs, id_valid, id_pc, imem_req);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i != 0) settle();
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_inst !== mem_data(32'(i * 4))) begin
                n_fail++;
                $display("FAIL bp_drain[%0d]: valid=%b pc=%h inst=%h, required valid=1 pc=%h inst=%h",
                         i, id_valid, id_pc, id_inst, 32'(i * 4), mem_data(32'(i * 4)));
            end
            advance();
        end
        for (int c = 0; c < 4 && !found; c++) begin
            settle();
            if (imem_req === 1'b1) begin
                found = 1'b1;
                n_checks++;
                if (imem_addr !== 32'h8) begin
                    n_fail++;
                    $display("FAIL bp_resume_addr: got %h, required 00000008", imem_addr);
                end
            end
            advance();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL bp_resume: got no request within 4 cycles, required a request at 00000008");
        end
    endtask

    task automatic test_flush_pending();
        do_reset(32'h8, 3, 3);
        id_ready = 1'b1;
        settle();
        advance();
        flush = 1'b1;
        redirect_pc = 32'h100;
        settle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || pc_advance !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_flush_cycle: req=%b addr=%h adv=%b, required req=1 addr=00000008 adv=0",
                     imem_req, imem_addr, pc_advance);
        end
        advance();
        flush = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            settle();
            n_checks++;
            if (id_valid !== 1'b0 || pc_advance !== 1'b0) begin
                n_fail++;
                $display("FAIL fp_no_data c%0d: valid=%b pc=%h adv=%b, required valid=0 adv=0",
                         c, id_valid, id_pc, pc_advance);
            end
            if (c <= 4) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                    n_fail++;
                    $display("FAIL fp_drop_hold c%0d: req=%b addr=%h, required req=1 addr=00000008",
                             c, imem_req, imem_addr);
                end
            end else if (c == 6) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
                    n_fail++;
                    $display("FAIL fp_redirect: req=%b addr=%h, required req=1 addr=00000100", imem_req, imem_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush_ack();
        do_reset(32'h40, 1, 1);
        id_ready = 1'b1;
        settle();
        advance();
        settle();
        advance();
        flush = 1'b1;
        redirect_pc = 32'h200;
        settle();
        n_checks++;
        if (imem_ack !== 1'b1 || pc_advance !== 1'b0 || id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fa_ack_cycle: ack=%b adv=%b valid=%b, required ack=1 adv=0 valid=0",
                     imem_ack, pc_advance, id_valid);
        end
        advance();
        flush = 1'b0;
        settle();
        n_checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fa_after: valid=%b req=%b, required valid=0 req=0", id_valid, imem_req);
        end
        advance();
        settle();
        n_checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL fa_refetch: valid=%b req=%b addr=%h, required valid=0 req=1 addr=00000200",
                     id_valid, imem_req, imem_addr);
        end
        advance();
    endtask

    task automatic test_ack_latency();
        do_reset(32'h10, 0, 0);
        id_ready = 1'b1;
        settle();
        advance();
        for (int c = 1; c <= 2; c++) begin
            bit want = BYP ? (c == 1) : (c == 2);
            settle();
            n_checks++;
            if (id_valid !== want || (want && (id_inst !== 32'h2008_0005 || id_pc !== 32'h10)) ||
                pc_advance !== (c == 1)) begin
                n_fail++;
                $display("FAIL ack_latency c%0d: valid=%b inst=%h pc=%h adv=%b, required valid=%b inst=20080005 pc=00000010 adv=%b",
                         c, id_valid, id_inst, id_pc, pc_advance, want, (c == 1));
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset(32'h0, 0, 3);
        for (int c = 0; c < 600; c++) begin
            id_ready    = ($urandom_range(9, 0) < 7);
            flush       = ($urandom_range(19, 0) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            rst         = ($urandom_range(99, 0) == 0);
            settle();
            n_checks++;
            if (imem_req !== m_busy || imem_addr !== m_addr || pc_advance !== exp_adv) begin
                n_fail++;
                $display("FAIL rand_fetch c%0d: req=%b addr=%h adv=%b, required req=%b addr=%h adv=%b",
                         c, imem_req, imem_addr, pc_advance, m_busy, m_addr, exp_adv);
            end
            n_checks++;
            if (id_valid !== exp_valid || id_pc !== exp_head.pc || id_inst !== exp_head.inst) begin
                n_fail++;
                $display("FAIL rand_decode c%0d: valid=%b pc=%h inst=%h, required valid=%b pc=%h inst=%h",
                         c, id_valid, id_pc, id_inst, exp_valid, exp_head.pc, exp_head.inst);
            end
            n_checks++;
            if (pc_plus4 !== pc_addr + 32'd4) begin
                n_fail++;
                $display("FAIL rand_pc_plus4 c%0d: got %h, required %h", c, pc_plus4, pc_addr + 32'd4);
            end
            advance();
        end
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_pending();
        test_flush_ack();
        test_ack_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_buffer.md
# ifetch_buffer

Instruction-fetch front end between the `pc` register and decode. It takes the current fetch address from `pc`, issues a single-outstanding request to instruction memory, and buffers returned instructions with their PCs in a 2-entry FIFO for the decode stage. It pulses `pc_advance` so that `pc` steps to `pc_plus4`, and it discards in-flight fetches when the pipeline redirects.

## Interface
- No parameters; depth fixed at 2 entries, data and address widths fixed at 32.
- `pc_clk` in 1: pipeline clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_addr` in 32: current fetch address from `pc`.
- `pc_plus4` out 32: `pc_addr + 4`, combinational, mod 2^32; feeds the `pc` sequential-next input.
- `pc_advance` out 1: one-cycle pulse; `pc` loads `pc_plus4` at the next edge.
- `flush` in 1: redirect (jump/jr taken); kills buffered and in-flight fetches.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request address, stable while `imem_req`=1.
- `imem_ack` in 1: response strobe; valid only while `imem_req`=1.
- `imem_rdata` in 32: instruction, valid when `imem_ack`=1.
- `id_valid` out 1: FIFO head valid.
- `id_inst` out 32: head instruction.
- `id_pc` out 32: head instruction address.
- `id_ready` in 1: decode accepts the head this cycle.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DROP: request outstanding, response to be discarded.
- IDLE -> REQ when `flush`=0 and `count` < 2. On that edge `imem_addr` <= `pc_addr` and `imem_req` <= 1.
- REQ + `imem_ack` + `flush`=0:
  - push {`imem_addr`, `imem_rdata`};
  - `pc_advance`=1 in that cycle;
  - `imem_req` <= 0; state -> IDLE.
- REQ + `flush` + no ack: state -> DROP; `imem_req` stays 1 and `imem_addr` is unchanged, because a request is never withdrawn.
- REQ + `flush` + `imem_ack`: data discarded, `pc_advance`=0, state -> IDLE.
- DROP + `imem_ack`: data discarded, `pc_advance`=0, state -> IDLE. `flush` in DROP has no extra effect.
- Pop when `id_valid` && `id_ready`. Push and pop in the same cycle are allowed, including when `count`=2, because the issue rule guarantees room.
- `flush` clears `count` to 0 at the edge; it takes priority over push and pop.
- `id_valid` = (`count` != 0). `id_inst`/`id_pc` come from the head entry. When empty, they hold their last value; the value is 0 after reset.
- `pc_advance` is never asserted in IDLE or DROP.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `pc_advance`=0, `id_valid`=0, `id_inst`=0, `id_pc`=0, state IDLE, `count`=0.
- Reset mid-request forces IDLE immediately. Memory shares `rst` and abandons the request.
- Latency from `pc_addr` valid in IDLE to request: `imem_req`=1 in the next cycle.
- Latency from `imem_ack` to decode: `id_valid`=1 in the cycle after the ack (without bypass).
- Peak throughput with a 1-cycle ack: one instruction every 2 cycles (IDLE, REQ).
- The updated `pc_addr` is sampled in IDLE the cycle after `pc_advance`.
- After `flush` at edge N, `id_valid`=0 in cycle N+1.

## Configuration
- `IFETCH_BYPASS_EN` defined:
  - When a valid (non-discarded) ack arrives with `count`=0 and `id_ready`=1, `imem_rdata`/`imem_addr` drive `id_inst`/`id_pc` combinationally and `id_valid`=1 in the ack cycle.
  - The entry is consumed without being written to the FIFO.
  - Latency from ack to decode is 0.
- `IFETCH_BYPASS_EN` undefined: every response goes through the FIFO, with 1 cycle of latency.

## Test plan
- Reset and idle:
  - Stimulus: `rst`=1 for 2 cycles, then release with `pc_addr`=0x0.
  - Required: all outputs 0 during reset; `imem_req`=1 with `imem_addr`=0x0 one cycle after release.
- Streaming:
  - Stimulus: ack one cycle after each request, `rdata` = addr^0xFFFF0000, `id_ready`=1, starting at `pc_addr`=0x0.
  - Required: `id_pc` sequence 0x0, 0x4, 0x8 with matching `id_inst`; `pc_advance` pulses every 2nd cycle.
- Backpressure:
  - Stimulus: `id_ready`=0.
  - Required: exactly 2 entries buffered (PCs 0x0, 0x4); `imem_req` stays 0 afterwards; `pc_advance` count = 2.
  - Then: raise `id_ready`; entries drain in order and fetch resumes at 0x8.
- Flush during outstanding request:
  - Stimulus: request at 0x8 pending, ack delayed 3 cycles, `flush` pulsed in the 1st cycle.
  - Required: state DROP; the 0x8 data is never presented; no `pc_advance`.
  - Then: with `pc_addr`=0x100, the next request is at 0x100.
- Flush coincident with ack:
  - Required: data dropped, `pc_advance`=0, `id_valid`=0 the next cycle, FIFO empty.
- Bypass (`IFETCH_BYPASS_EN`):
  - Stimulus: FIFO empty, `id_ready`=1, ack with `rdata`=0x20080005 at 0x10.
  - Required: `id_valid`=1, `id_inst`=0x20080005, `id_pc`=0x10 in the same cycle; `count` stays 0.
